nh_lcd_data_reader: RTL
=======================

// Module: nh_lcd_data_reader
// PURPOSE
//  Reads pixel data back from the NH LCD controller over the 8-bit 8080-style bus, the read-side
//  counterpart of the LCD pixel writer. It issues CMD_START_MEM_READ, turns the bus around and
//  strobes reads. Each R,G,B byte triple is packed into one 24-bit pixel and pushed into the
//  host-bound ping-pong FIFO.
// PARAMETERS
//  READ_LOW_CYCLES   4   cycles o_read held high per byte (>=1); i_data_in sampled on the last one
//  READ_HIGH_CYCLES  2   recovery cycles with o_read low between bytes (>=1)
// PORTS
//  clk              in   1   single clock for the block
//  rst              in   1   reset, asynchronous, active-high
//  i_enable         in   1   block enable; low aborts any transfer
//  i_start          in   1   one-cycle pulse: begin a read of i_num_pixels
//  i_num_pixels     in   32  pixels to read; sampled on i_start
//  o_busy           out  1   high from accepted i_start until return to IDLE
//  o_done           out  1   one-cycle pulse when the last pixel is pushed, or when i_num_pixels==0
//  i_wfifo_rdy      in   2   ping-pong FIFO write side: channel ready
//  o_wfifo_act      out  2   channel activate (one-hot or 0)
//  i_wfifo_size     in   24  capacity of the activated channel
//  o_wfifo_stb      out  1   write strobe, one cycle per pixel
//  o_wfifo_data     out  24  {R,G,B}
//  o_cmd_mode       out  1   0 = command byte, 1 = data
//  o_data_out       out  8   bus drive value
//  i_data_in        in   8   bus read value
//  o_write          out  1   one-cycle write strobe
//  o_read           out  1   read strobe (high = active phase)
//  o_data_out_en    out  1   1 = block drives bus, 0 = bus released to LCD
// BEHAVIOUR
//  Reset values: o_data_out=CMD_START_MEM_READ (8'h2E), o_data_out_en=1, o_cmd_mode=1.
//    All other outputs are 0. All counters are 0 and the state is IDLE.
//  States: IDLE, GET_FIFO, WRITE_CMD, TURNAROUND, READ_LOW, READ_HIGH, PUSH, FINISH.
//  IDLE: bus driven with 8'h2E.
//    i_start && i_enable && i_num_pixels!=0 -> latch count, o_busy=1, go to GET_FIFO.
//    i_num_pixels==0 -> o_done pulse, stay in IDLE.
//  GET_FIFO: wait for o_wfifo_act==0 and i_wfifo_rdy!=0.
//    Activate channel 0 if rdy[0], else channel 1. Clear the FIFO fill count.
//    If the command has not been sent yet -> WRITE_CMD; otherwise -> READ_LOW (resume).
//  WRITE_CMD: o_cmd_mode=0 and o_write=1 for exactly one cycle -> TURNAROUND.
//  TURNAROUND: o_data_out_en=0, one full cycle with no strobes -> READ_LOW.
//    o_data_out_en stays 0 until FINISH or abort.
//  READ_LOW: o_read=1 for READ_LOW_CYCLES. Capture i_data_in on the last cycle into byte slot
//    R/G/B (index 0/1/2) -> READ_HIGH.
//  READ_HIGH: o_read=0 for READ_HIGH_CYCLES. Then: index 2 -> PUSH, otherwise index+1 -> READ_LOW.
//  PUSH: o_wfifo_stb=1 with {R,G,B}. Increment the pixel count and the FIFO fill count.
//    Then, in priority order:
//    - pixel count == latched count -> o_wfifo_act=0, go to FINISH;
//    - FIFO fill == i_wfifo_size -> o_wfifo_act=0, go to GET_FIFO;
//    - otherwise -> READ_LOW.
//  FINISH: o_data_out_en=1, o_data_out=8'h2E, o_done pulse, o_busy=0 -> IDLE.
//  Per-pixel time: 3*(READ_LOW_CYCLES+READ_HIGH_CYCLES)+1 cycles (PUSH).
//    No o_read is issued while no channel is active.
//  Abort: i_enable low in any non-IDLE state, takes effect next cycle.
//    o_read=0, o_wfifo_act=0 (partial block committed), o_data_out_en=1, no o_done, go to IDLE.
//  i_start while busy is ignored. Pixel count is 32-bit and compared with ==; it never wraps
//    within one transfer.
//  Asserting rst mid-transfer returns all outputs to reset values immediately.
// CONFIGURATION
//  NH_LCD_READ_DUMMY_EN defined: the first byte after TURNAROUND is a dummy. It gets a full
//    READ_LOW/READ_HIGH strobe, is discarded and does not advance the byte index.
//    Per-pixel timing is otherwise unchanged.
//  NH_LCD_READ_DUMMY_EN undefined: the first byte read is R of pixel 0.
// STRUCTURE
//  nh_lcd_defines.v: CMD_START_MEM_READ (8'h2E) alongside the existing command defines.
//  Keep the state encodings local.
//  Sub-module nh_lcd_read_strobe: takes a go pulse and produces o_read, the sample pulse and the
//    done pulse using the READ_LOW_CYCLES/READ_HIGH_CYCLES counters.
// TESTING
//  1. 1 pixel, L=4, H=2, LCD returns 8'h11,8'h22,8'h33 -> cmd 8'h2E with o_cmd_mode=0;
//     one o_wfifo_stb with 24'h112233; o_done 20 cycles after TURNAROUND.
//  2. 10 pixels, i_wfifo_size=4 -> act released after 4, 8 and 10 pixels; channels alternate 0/1;
//     the command is written only once.
//  3. NH_LCD_READ_DUMMY_EN, bytes 8'hAA,8'h01,8'h02,8'h03 -> 8'hAA dropped, data 24'h010203.
//  4. i_num_pixels=0 -> o_done the cycle after i_start; no o_write/o_read; bus never released.
//  5. i_enable low during READ_LOW of pixel 3 -> next cycle o_read=0, o_wfifo_act=0,
//     o_data_out_en=1, IDLE, no o_done.
//  6. i_wfifo_rdy=0 for 50 cycles after i_start -> stays in GET_FIFO, no bus strobes;
//     proceeds once rdy[1]=1 with o_wfifo_act=2'b10.

Source files
------------

// File: rtl/nh_lcd_data_reader_pkg.sv
// Shared constants, pixel packing type and FIFO channel selection for the NH LCD pixel reader.
package nh_lcd_data_reader_pkg;

    localparam logic [7:0] CMD_START_MEM_READ = 8'h2E;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Channel 0 wins when both are ready; only called with at least one bit set.
    function automatic logic [1:0] pick_channel(input logic [1:0] rdy);
        return rdy[0] ? 2'b01 : {rdy[1], 1'b0};
    endfunction

endpackage

// File: rtl/nh_lcd_data_reader_if.sv
// Host control, ping-pong FIFO write side and 8080 bus signals of the NH LCD pixel reader.
interface nh_lcd_data_reader_if;
    logic        i_enable;
    logic        i_start;
    logic [31:0] i_num_pixels;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  i_wfifo_rdy;
    logic [1:0]  o_wfifo_act;
    logic [23:0] i_wfifo_size;
    logic        o_wfifo_stb;
    logic [23:0] o_wfifo_data;
    logic        o_cmd_mode;
    logic [7:0]  o_data_out;
    logic [7:0]  i_data_in;
    logic        o_write;
    logic        o_read;
    logic        o_data_out_en;

    modport master (
        input  i_enable, i_start, i_num_pixels, i_wfifo_rdy, i_wfifo_size, i_data_in,
        output o_busy, o_done, o_wfifo_act, o_wfifo_stb, o_wfifo_data,
               o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en
    );

    modport slave (
        output i_enable, i_start, i_num_pixels, i_wfifo_rdy, i_wfifo_size, i_data_in,
        input  o_busy, o_done, o_wfifo_act, o_wfifo_stb, o_wfifo_data,
               o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en
    );
endinterface

// File: rtl/nh_lcd_read_strobe.sv
// One byte read cycle: o_read high for LOW_CYCLES, then low for HIGH_CYCLES recovery.
module nh_lcd_read_strobe #(
    parameter int LOW_CYCLES  = 4,
    parameter int HIGH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic go_i,
    input  logic clr_i,
    output logic read_o,
    output logic sample_o,
    output logic done_o
);
    localparam int MAX_CYCLES = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    logic          low_q, low_d;
    logic          high_q, high_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign read_o   = low_q;
    assign sample_o = low_q  && (cnt_q == CW'(LOW_CYCLES - 1));
    assign done_o   = high_q && (cnt_q == CW'(HIGH_CYCLES - 1));

    always_comb begin
        low_d  = low_q;
        high_d = high_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            low_d  = 1'b0;
            high_d = 1'b0;
            cnt_d  = '0;
        end else if (go_i) begin
            // go may coincide with done_o when bytes run back to back
            low_d  = 1'b1;
            high_d = 1'b0;
            cnt_d  = '0;
        end else if (sample_o) begin
            low_d  = 1'b0;
            high_d = 1'b1;
            cnt_d  = '0;
        end else if (done_o) begin
            high_d = 1'b0;
            cnt_d  = '0;
        end else if (low_q || high_q) begin
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_q  <= 1'b0;
            high_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            low_q  <= low_d;
            high_q <= high_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/nh_lcd_data_reader.sv
// Reads R,G,B bytes back from the NH LCD after CMD_START_MEM_READ and pushes packed pixels to a
// ping-pong FIFO. Define NH_LCD_READ_DUMMY_EN to discard the first byte after bus turnaround.
module nh_lcd_data_reader
    import nh_lcd_data_reader_pkg::*;
#(
    parameter int READ_LOW_CYCLES  = 4,
    parameter int READ_HIGH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    nh_lcd_data_reader_if.master  lcd
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_GET_FIFO, ST_WRITE_CMD, ST_TURNAROUND,
        ST_READ_LOW, ST_READ_HIGH, ST_PUSH, ST_FINISH
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pix_q, pix_d;
    logic [23:0] fill_q, fill_d;
    logic [1:0]  idx_q, idx_d;
    pixel_t      pixel_q, pixel_d;
    logic [1:0]  act_q, act_d;
    logic        bus_rel_q, bus_rel_d;
    logic        zero_done_q, zero_done_d;
    logic        dummy_q, dummy_d;

    logic abort;
    logic go;
    logic rd_read, rd_sample, rd_done;

    assign abort = !lcd.i_enable && (state_q != ST_IDLE);

    nh_lcd_read_strobe #(
        .LOW_CYCLES  (READ_LOW_CYCLES),
        .HIGH_CYCLES (READ_HIGH_CYCLES)
    ) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .go_i     (go),
        .clr_i    (abort),
        .read_o   (rd_read),
        .sample_o (rd_sample),
        .done_o   (rd_done)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            pix_q       <= '0;
            fill_q      <= '0;
            idx_q       <= '0;
            pixel_q     <= '0;
            act_q       <= '0;
            bus_rel_q   <= 1'b0;
            zero_done_q <= 1'b0;
            dummy_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pix_q       <= pix_d;
            fill_q      <= fill_d;
            idx_q       <= idx_d;
            pixel_q     <= pixel_d;
            act_q       <= act_d;
            bus_rel_q   <= bus_rel_d;
            zero_done_q <= zero_done_d;
            dummy_q     <= dummy_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pix_d       = pix_q;
        fill_d      = fill_q;
        idx_d       = idx_q;
        pixel_d     = pixel_q;
        act_d       = act_q;
        bus_rel_d   = bus_rel_q;
        zero_done_d = 1'b0;
        dummy_d     = dummy_q;
        go          = 1'b0;

        if (abort) begin
            state_d   = ST_IDLE;
            act_d     = '0;
            bus_rel_d = 1'b0;
            dummy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lcd.i_start && lcd.i_enable) begin
                        if (lcd.i_num_pixels == '0) begin
                            zero_done_d = 1'b1;
                        end else begin
                            count_d = lcd.i_num_pixels;
                            pix_d   = '0;
                            idx_d   = '0;
                            state_d = ST_GET_FIFO;
                        end
                    end
                end
                ST_GET_FIFO: begin
                    if (act_q == '0 && lcd.i_wfifo_rdy != '0) begin
                        act_d  = pick_channel(lcd.i_wfifo_rdy);
                        fill_d = '0;
                        // A released bus means the command already went out: resume reading.
                        if (bus_rel_q) begin
                            state_d = ST_READ_LOW;
                            go      = 1'b1;
                        end else begin
                            state_d = ST_WRITE_CMD;
                        end
                    end
                end
                ST_WRITE_CMD: state_d = ST_TURNAROUND;
                ST_TURNAROUND: begin
                    bus_rel_d = 1'b1;
`ifdef NH_LCD_READ_DUMMY_EN
                    dummy_d   = 1'b1;
`else
                    dummy_d   = 1'b0;
`endif
                    state_d   = ST_READ_LOW;
                    go        = 1'b1;
                end
                ST_READ_LOW: begin
                    if (rd_sample) begin
                        state_d = ST_READ_HIGH;
                        if (!dummy_q) begin
                            case (idx_q)
                                2'd0:    pixel_d.r = lcd.i_data_in;
                                2'd1:    pixel_d.g = lcd.i_data_in;
                                default: pixel_d.b = lcd.i_data_in;
                            endcase
                        end
                    end
                end
                ST_READ_HIGH: begin
                    if (rd_done) begin
                        if (dummy_q) begin
                            dummy_d = 1'b0;
                            state_d = ST_READ_LOW;
                            go      = 1'b1;
                        end else if (idx_q == 2'd2) begin
                            state_d = ST_PUSH;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = ST_READ_LOW;
                            go      = 1'b1;
                        end
                    end
                end
                ST_PUSH: begin
                    pix_d  = pix_q + 32'd1;
                    fill_d = fill_q + 24'd1;
                    idx_d  = '0;
                    if (pix_q + 32'd1 == count_q) begin
                        act_d     = '0;
                        bus_rel_d = 1'b0;
                        state_d   = ST_FINISH;
                    end else if (fill_q + 24'd1 == lcd.i_wfifo_size) begin
                        act_d   = '0;
                        state_d = ST_GET_FIFO;
                    end else begin
                        state_d = ST_READ_LOW;
                        go      = 1'b1;
                    end
                end
                ST_FINISH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lcd.o_busy        = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        lcd.o_done        = (state_q == ST_FINISH) || zero_done_q;
        lcd.o_wfifo_act   = act_q;
        lcd.o_wfifo_stb   = (state_q == ST_PUSH);
        lcd.o_wfifo_data  = pixel_q;
        lcd.o_cmd_mode    = (state_q != ST_WRITE_CMD);
        lcd.o_data_out    = CMD_START_MEM_READ;
        lcd.o_write       = (state_q == ST_WRITE_CMD);
        lcd.o_read        = rd_read;
        lcd.o_data_out_en = !(bus_rel_q || state_q == ST_TURNAROUND);
    end

endmodule
